msrv32_su: RTL and testbench

Store unit for the msrv32 core: takes a store request from the execute stage, aligns the rs2 data and byte-lane mask to the addressed word, and drives a single AHB-Lite-style write transfer to data memory. The transfer has a registered address phase and a data phase. The unit stalls the pipeline until the transfer completes and reports completion, bus errors and misaligned stores to the trap logic. It is the write-side counterpart of the load unit on the same data-memory interface.

---
 rtl/msrv32_su.sv | 164 ++++++++++++++++
 tb/tb_msrv32_su.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_su.sv
// -----------------------------------------------------------------------------
// msrv32_su -- store unit for the msrv32 core
//
// Takes one store request from the execute stage, aligns the rs2 value and
// the byte-lane strobes to the addressed 32-bit word, and performs a single
// AHB-Lite-style write transfer: a registered address phase followed by a
// data phase. The pipeline is stalled (busy_out) for the whole transfer.
// Completion, bus errors and misaligned stores are reported as one-cycle
// pulses to the trap logic.
//
// Ports
//   clk_in          core clock, rising edge
//   rst_in          synchronous active-high reset
//   store_req_in    store request, sampled only in IDLE
//   store_size_in   00 byte, 01 halfword, 10/11 word
//   store_data_in   rs2 value (unaligned, low bits significant)
//   iadder_in       effective byte address
//   ahb_ready_in    HREADY from data memory
//   ahb_resp_in     HRESP (0 OKAY / 1 ERROR), meaningful with ready in DATA
//   wr_req_out      address-phase valid (write)
//   addr_out        word-aligned address, valid in address phase
//   wr_mask_out     byte-lane strobes, valid in address phase
//   wr_data_out     lane-replicated write data, valid in data phase
//   busy_out        pipeline stall, high whenever the FSM is not IDLE
//   done_out        one-cycle completion pulse
//   bus_err_out     one-cycle error pulse, coincident with done_out
//   misaligned_out  one-cycle pulse for a rejected misaligned store
//
// Handshake: the address phase is offered while wr_req_out=1 and is taken on
// the first rising edge where ahb_ready_in=1; the data phase is likewise
// held until a rising edge with ahb_ready_in=1, at which ahb_resp_in is
// sampled. While ahb_ready_in=0 every bus output is held unchanged. Toward
// the pipeline, store_req_in is a valid that is only looked at in IDLE; the
// pipeline keeps the request inputs stable while busy_out=1.
// -----------------------------------------------------------------------------
module msrv32_su (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        store_req_in,
   input  logic [1:0]  store_size_in,
   input  logic [31:0] store_data_in,
   input  logic [31:0] iadder_in,
   input  logic        ahb_ready_in,
   input  logic        ahb_resp_in,
   output logic        wr_req_out,
   output logic [31:0] addr_out,
   output logic [3:0]  wr_mask_out,
   output logic [31:0] wr_data_out,
   output logic        busy_out,
   output logic        done_out,
   output logic        bus_err_out,
   output logic        misaligned_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_data;      // replicated write data, waiting for the data phase

   logic        w_misaligned;
   logic [3:0]  w_mask;
   logic [31:0] w_rep_data;

   // Request decode: alignment check, lane strobes and lane replication.
   // Size 2'b11 is treated as a word store.
   always_comb begin
      w_misaligned = 1'b0;
      w_mask       = 4'b1111;
      w_rep_data   = store_data_in;
      case (store_size_in)
         2'b00: begin
            w_mask     = 4'b0001 << iadder_in[1:0];
            w_rep_data = {4{store_data_in[7:0]}};
         end
         2'b01: begin
            w_misaligned = iadder_in[0];
            w_mask       = iadder_in[1] ? 4'b1100 : 4'b0011;
            w_rep_data   = {2{store_data_in[15:0]}};
         end
         default: begin
            w_misaligned = (iadder_in[1:0] != 2'b00);
            w_mask       = 4'b1111;
            w_rep_data   = store_data_in;
         end
      endcase
   end

   // Only combinational output: stall is a pure decode of the state register.
   assign busy_out = (r_state != S_IDLE);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state        <= S_IDLE;
         r_data         <= 32'd0;
         wr_req_out     <= 1'b0;
         addr_out       <= 32'd0;
         wr_mask_out    <= 4'd0;
         wr_data_out    <= 32'd0;
         done_out       <= 1'b0;
         bus_err_out    <= 1'b0;
         misaligned_out <= 1'b0;
      end else begin
         // Status outputs are single-cycle pulses unless re-armed below.
         done_out       <= 1'b0;
         bus_err_out    <= 1'b0;
         misaligned_out <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (store_req_in) begin
                  if (w_misaligned) begin
                     // Rejected: report and stay idle, bus untouched.
                     misaligned_out <= 1'b1;
                  end else begin
                     r_state     <= S_ADDR;
                     r_data      <= w_rep_data;
                     wr_req_out  <= 1'b1;
                     addr_out    <= {iadder_in[31:2], 2'b00};
                     wr_mask_out <= w_mask;
                  end
               end
            end
            S_ADDR: begin
               if (ahb_ready_in) begin
                  r_state     <= S_DATA;
                  wr_req_out  <= 1'b0;
                  addr_out    <= 32'd0;
                  wr_mask_out <= 4'd0;
                  wr_data_out <= r_data;
               end
            end
            S_DATA: begin
               if (ahb_ready_in) begin
                  r_state     <= S_IDLE;
                  wr_data_out <= 32'd0;
                  done_out    <= 1'b1;
                  bus_err_out <= ahb_resp_in;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               wr_req_out  <= 1'b0;
               addr_out    <= 32'd0;
               wr_mask_out <= 4'd0;
               wr_data_out <= 32'd0;
            end
         endcase
      end
   end

   // Pulse-shape properties of the trap-facing outputs.
   a_done_one_cycle : assert property (@(posedge clk_in) disable iff (rst_in)
      done_out |=> !done_out);
   a_mis_one_cycle : assert property (@(posedge clk_in) disable iff (rst_in)
      misaligned_out |=> !misaligned_out);
   a_err_with_done : assert property (@(posedge clk_in) disable iff (rst_in)
      bus_err_out |-> done_out);
   a_mis_not_done : assert property (@(posedge clk_in) disable iff (rst_in)
      !(misaligned_out && done_out));

endmodule

// File: tb/tb_msrv32_su.sv
// -----------------------------------------------------------------------------
// tb_msrv32_su -- directed self-checking bench for the msrv32 store unit.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_msrv32_su;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        store_req_in;
   logic [1:0]  store_size_in;
   logic [31:0] store_data_in;
   logic [31:0] iadder_in;
   logic        ahb_ready_in;
   logic        ahb_resp_in;
   logic        wr_req_out;
   logic [31:0] addr_out;
   logic [3:0]  wr_mask_out;
   logic [31:0] wr_data_out;
   logic        busy_out;
   logic        done_out;
   logic        bus_err_out;
   logic        misaligned_out;

   int n_tests = 0;
   int n_fail  = 0;

   msrv32_su dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .store_req_in   (store_req_in),
      .store_size_in  (store_size_in),
      .store_data_in  (store_data_in),
      .iadder_in      (iadder_in),
      .ahb_ready_in   (ahb_ready_in),
      .ahb_resp_in    (ahb_resp_in),
      .wr_req_out     (wr_req_out),
      .addr_out       (addr_out),
      .wr_mask_out    (wr_mask_out),
      .wr_data_out    (wr_data_out),
      .busy_out       (busy_out),
      .done_out       (done_out),
      .bus_err_out    (bus_err_out),
      .misaligned_out (misaligned_out)
   );

   // ---------------- clock ----------------
   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Drives one store with ready=1 throughout. Returns what was seen in the
   // address-phase cycle, the data-phase cycle and the completion cycle.
   // The caller's request is accepted on the first edge.
   task automatic run_store(input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input logic resp,
                            output logic o_areq, output logic [31:0] o_addr,
                            output logic [3:0] o_mask, output logic o_abusy,
                            output logic o_dreq, output logic [31:0] o_data,
                            output logic o_done, output logic o_err,
                            output logic o_ebusy);
      store_req_in  = 1'b1;
      store_size_in = sz;
      store_data_in = d;
      iadder_in     = a;
      ahb_ready_in  = 1'b1;
      ahb_resp_in   = 1'b0;
      tick();
      o_areq  = wr_req_out;
      o_addr  = addr_out;
      o_mask  = wr_mask_out;
      o_abusy = busy_out;
      store_req_in = 1'b0;
      ahb_resp_in  = resp;
      tick();
      o_dreq = wr_req_out;
      o_data = wr_data_out;
      tick();
      o_done  = done_out;
      o_err   = bus_err_out;
      o_ebusy = busy_out;
      ahb_resp_in = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_in        = 1'b1;
      store_req_in  = 1'b0;
      store_size_in = 2'b00;
      store_data_in = 32'd0;
      iadder_in     = 32'd0;
      ahb_ready_in  = 1'b1;
      ahb_resp_in   = 1'b0;
      tick();
      tick();
      n_tests++;
      if ({wr_req_out, addr_out, wr_mask_out, wr_data_out, busy_out, done_out,
           bus_err_out, misaligned_out} !== 73'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b addr=%h mask=%b data=%h busy=%b done=%b err=%b mis=%b, all required 0",
                  wr_req_out, addr_out, wr_mask_out, wr_data_out, busy_out, done_out, bus_err_out, misaligned_out);
      end
      rst_in = 1'b0;
      tick();
   endtask

   task automatic test_word();
      logic areq, abusy, dreq, done, err, ebusy;
      logic [31:0] addr, data;
      logic [3:0]  mask;
      run_store(2'b10, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0,
                areq, addr, mask, abusy, dreq, data, done, err, ebusy);
      n_tests++;
      if ({areq, abusy, addr, mask} !== {1'b1, 1'b1, 32'h0000_1004, 4'b1111}) begin
         n_fail++;
         $display("FAIL word_addr_phase: req=%b busy=%b addr=%h mask=%b, required 1 1 00001004 1111",
                  areq, abusy, addr, mask);
      end
      n_tests++;
      if ({dreq, data} !== {1'b0, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL word_data_phase: req=%b data=%h, required 0 deadbeef", dreq, data);
      end
      n_tests++;
      if ({done, err, ebusy} !== 3'b100) begin
         n_fail++;
         $display("FAIL word_done: done=%b err=%b busy=%b, required 1 0 0", done, err, ebusy);
      end
      tick();
      n_tests++;
      if ({done_out, wr_data_out} !== 33'd0) begin
         n_fail++;
         $display("FAIL word_after_done: done=%b data=%h, required 0 0", done_out, wr_data_out);
      end
   endtask

   task automatic test_byte();
      logic areq, abusy, dreq, done, err, ebusy;
      logic [31:0] addr, data, din;
      logic [3:0]  mask, exp_mask;
      for (int k = 0; k < 4; k++) begin
         // Upper junk bits must not leak into the replicated byte.
         din      = (k == 3) ? 32'h0000_00A5 : 32'h7766_55A5;
         exp_mask = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : (k == 2) ? 4'b0100 : 4'b1000;
         run_store(2'b00, 32'h0000_2000 + k, din, 1'b0,
                   areq, addr, mask, abusy, dreq, data, done, err, ebusy);
         n_tests++;
         if ({areq, addr, mask, data, done} !== {1'b1, 32'h0000_2000, exp_mask, 32'hA5A5_A5A5, 1'b1}) begin
            n_fail++;
            $display("FAIL byte_off%0d: req=%b addr=%h mask=%b data=%h done=%b, required 1 00002000 %b a5a5a5a5 1",
                     k, areq, addr, mask, data, done, exp_mask);
         end
      end
   endtask

   task automatic test_half();
      logic areq, abusy, dreq, done, err, ebusy;
      logic [31:0] addr, data;
      logic [3:0]  mask;
      run_store(2'b01, 32'h0000_3002, 32'h1234_BEEF, 1'b0,
                areq, addr, mask, abusy, dreq, data, done, err, ebusy);
      n_tests++;
      if ({addr, mask, data, done} !== {32'h0000_3000, 4'b1100, 32'hBEEF_BEEF, 1'b1}) begin
         n_fail++;
         $display("FAIL half_hi: addr=%h mask=%b data=%h done=%b, required 00003000 1100 beefbeef 1",
                  addr, mask, data, done);
      end
      run_store(2'b01, 32'h0000_3000, 32'hCAFE_0123, 1'b0,
                areq, addr, mask, abusy, dreq, data, done, err, ebusy);
      n_tests++;
      if ({addr, mask, data, done} !== {32'h0000_3000, 4'b0011, 32'h0123_0123, 1'b1}) begin
         n_fail++;
         $display("FAIL half_lo: addr=%h mask=%b data=%h done=%b, required 00003000 0011 01230123 1",
                  addr, mask, data, done);
      end
      // Size 11 behaves as a word store.
      run_store(2'b11, 32'h0000_300C, 32'h0BAD_F00D, 1'b0,
                areq, addr, mask, abusy, dreq, data, done, err, ebusy);
      n_tests++;
      if ({addr, mask, data, done} !== {32'h0000_300C, 4'b1111, 32'h0BAD_F00D, 1'b1}) begin
         n_fail++;
         $display("FAIL size11_word: addr=%h mask=%b data=%h done=%b, required 0000300c 1111 0badf00d 1",
                  addr, mask, data, done);
      end
   endtask

   task automatic test_misaligned();
      logic [1:0]  sz[3]  = '{2'b01, 2'b10, 2'b11};
      logic [31:0] adr[3] = '{32'h0000_4001, 32'h0000_4002, 32'h0000_4003};
      for (int k = 0; k < 3; k++) begin
         store_req_in  = 1'b1;
         store_size_in = sz[k];
         iadder_in     = adr[k];
         store_data_in = 32'h5555_AAAA;
         tick();
         n_tests++;
         if ({misaligned_out, wr_req_out, busy_out, done_out} !== 4'b1000) begin
            n_fail++;
            $display("FAIL misaligned_%0d_pulse: mis=%b req=%b busy=%b done=%b, required 1 0 0 0",
                     k, misaligned_out, wr_req_out, busy_out, done_out);
         end
         store_req_in = 1'b0;
         tick();
         n_tests++;
         if ({misaligned_out, wr_req_out, busy_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL misaligned_%0d_after: mis=%b req=%b busy=%b, required 0 0 0",
                     k, misaligned_out, wr_req_out, busy_out);
         end
      end
   endtask

   // Ready low for 2 ADDR cycles and 3 DATA cycles, ERROR response at the end.
   // Cycle k after acceptance; rdy[k] is the ready seen at the edge ending it.
   task automatic test_stall_err();
      logic rdy[1:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        e_req, e_busy;
      logic [31:0] e_addr, e_data;
      logic [3:0]  e_mask;
      store_req_in  = 1'b1;
      store_size_in = 2'b10;
      store_data_in = 32'h1357_9BDF;
      iadder_in     = 32'h0000_5008;
      ahb_ready_in  = 1'b1;
      ahb_resp_in   = 1'b0;
      tick();
      store_req_in = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         e_req  = (k <= 3);
         e_addr = (k <= 3) ? 32'h0000_5008 : 32'd0;
         e_mask = (k <= 3) ? 4'b1111 : 4'b0000;
         e_data = (k <= 3) ? 32'd0 : 32'h1357_9BDF;
         e_busy = 1'b1;
         n_tests++;
         if ({wr_req_out, addr_out, wr_mask_out, wr_data_out, busy_out, done_out}
             !== {e_req, e_addr, e_mask, e_data, e_busy, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_cyc%0d: req=%b addr=%h mask=%b data=%h busy=%b done=%b, required %b %h %b %h 1 0",
                     k, wr_req_out, addr_out, wr_mask_out, wr_data_out, busy_out, done_out,
                     e_req, e_addr, e_mask, e_data);
         end
         ahb_ready_in = rdy[k];
         // Response driven only on the completing cycle; ERROR elsewhere must be ignored.
         ahb_resp_in  = (k == 7) ? 1'b1 : ((k == 3) ? 1'b1 : 1'b0);
         tick();
      end
      ahb_ready_in = 1'b1;
      ahb_resp_in  = 1'b0;
      n_tests++;
      if ({done_out, bus_err_out, busy_out, wr_data_out} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
         n_fail++;
         $display("FAIL stall_done_cyc8: done=%b err=%b busy=%b data=%h, required 1 1 0 0",
                  done_out, bus_err_out, busy_out, wr_data_out);
      end
      tick();
      n_tests++;
      if ({done_out, bus_err_out} !== 2'b00) begin
         n_fail++;
         $display("FAIL stall_pulse_end: done=%b err=%b, required 0 0", done_out, bus_err_out);
      end
   endtask

   task automatic test_reset_mid();
      logic areq, abusy, dreq, done, err, ebusy;
      logic [31:0] addr, data;
      logic [3:0]  mask;
      store_req_in  = 1'b1;
      store_size_in = 2'b10;
      store_data_in = 32'hFACE_B00C;
      iadder_in     = 32'h0000_6000;
      ahb_ready_in  = 1'b1;
      ahb_resp_in   = 1'b1;
      tick();
      store_req_in = 1'b0;
      tick();
      n_tests++;
      if ({busy_out, wr_data_out} !== {1'b1, 32'hFACE_B00C}) begin
         n_fail++;
         $display("FAIL rstmid_in_data: busy=%b data=%h, required 1 faceb00c", busy_out, wr_data_out);
      end
      rst_in = 1'b1;
      tick();
      rst_in      = 1'b0;
      ahb_resp_in = 1'b0;
      n_tests++;
      if ({wr_req_out, addr_out, wr_mask_out, wr_data_out, busy_out, done_out,
           bus_err_out, misaligned_out} !== 73'd0) begin
         n_fail++;
         $display("FAIL rstmid_cleared: req=%b addr=%h mask=%b data=%h busy=%b done=%b err=%b mis=%b, required all 0",
                  wr_req_out, addr_out, wr_mask_out, wr_data_out, busy_out, done_out, bus_err_out, misaligned_out);
      end
      tick();
      n_tests++;
      if ({done_out, bus_err_out, busy_out} !== 3'b000) begin
         n_fail++;
         $display("FAIL rstmid_no_done: done=%b err=%b busy=%b, required 0 0 0", done_out, bus_err_out, busy_out);
      end
      run_store(2'b00, 32'h0000_6001, 32'h0000_003C, 1'b0,
                areq, addr, mask, abusy, dreq, data, done, err, ebusy);
      n_tests++;
      if ({areq, addr, mask, data, done, err} !== {1'b1, 32'h0000_6000, 4'b0010, 32'h3C3C_3C3C, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL rstmid_next_byte: req=%b addr=%h mask=%b data=%h done=%b err=%b, required 1 00006000 0010 3c3c3c3c 1 0",
                  areq, addr, mask, data, done, err);
      end
   endtask

   task automatic test_back_to_back();
      logic areq, abusy, dreq, done, err, ebusy;
      logic [31:0] addr, data;
      logic [3:0]  mask;
      run_store(2'b10, 32'h0000_7000, 32'h1111_2222, 1'b0,
                areq, addr, mask, abusy, dreq, data, done, err, ebusy);
      n_tests++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first_done: done=%b, required 1", done);
      end
      // Second request presented in the done cycle of the first.
      run_store(2'b01, 32'h0000_7106, 32'h9999_4321, 1'b1,
                areq, addr, mask, abusy, dreq, data, done, err, ebusy);
      n_tests++;
      if ({areq, abusy, addr, mask, data, done, err}
          !== {1'b1, 1'b1, 32'h0000_7104, 4'b1100, 32'h4321_4321, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_second: req=%b busy=%b addr=%h mask=%b data=%h done=%b err=%b, required 1 1 00007104 1100 43214321 1 1",
                  areq, abusy, addr, mask, data, done, err);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misaligned();
      test_stall_err();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
